// File: rtl/rf_wb_scheduler_pkg.sv
// Shared constants for the register-file writeback scheduler.
package rf_wb_scheduler_pkg;

    localparam int unsigned REG_AW_DEF  = 5;
    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned NUM_SRC_DEF = 3;

    // Writeback source indices
    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_LSU = 1;
    localparam int unsigned SRC_MDU = 2;

    // Level of i_rst_n that holds the block in reset
    localparam logic RST_ACTIVE = 1'b0;

    // Width of a source index / pointer; never zero
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_picker.sv
// One-hot winner select over the eligible writeback sources.
// RF_WB_RR_EN defined: round-robin search starting at i_ptr.
// RF_WB_RR_EN undefined: fixed priority, lowest index wins, i_ptr ignored.
module rf_wb_picker
    import rf_wb_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DEF,
    parameter int unsigned PTR_W   = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_elig,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_grant,
    output logic [PTR_W-1:0]   o_winner,
    output logic               o_any
);

`ifdef RF_WB_RR_EN
    // First eligible source at or after the pointer, wrapping around
    always_comb begin
        int unsigned idx;
        idx      = 0;
        o_grant  = '0;
        o_winner = '0;
        o_any    = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = (32'(i_ptr) + i) % NUM_SRC;
            if (!o_any && i_elig[idx]) begin
                o_grant[idx] = 1'b1;
                o_winner     = PTR_W'(idx);
                o_any        = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^i_ptr;

    // Lowest-index eligible source wins
    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        o_any    = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!o_any && i_elig[i]) begin
                o_grant[i] = 1'b1;
                o_winner   = PTR_W'(i);
                o_any      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write port scheduler with pending-write scoreboard.
// Optional RF_WB_RR_EN selects round-robin arbitration (default: fixed priority).
module rf_wb_scheduler
    import rf_wb_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DEF,
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned REG_AW  = REG_AW_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_SRC-1:0]        i_req_valid,
    input  logic [NUM_SRC*REG_AW-1:0] i_req_rd,
    input  logic [NUM_SRC*XLEN-1:0]   i_req_data,
    output logic [NUM_SRC-1:0]        o_req_ready,
    output logic [REG_AW-1:0]         o_rd_waddr,
    output logic [XLEN-1:0]           o_rd_wdata,
    input  logic                      i_issue_valid,
    input  logic [REG_AW-1:0]         i_issue_rd,
    output logic                      o_issue_ready,
    input  logic                      i_flush,
    input  logic [REG_AW-1:0]         i_rs1_addr,
    input  logic [REG_AW-1:0]         i_rs2_addr,
    output logic                      o_rs1_busy,
    output logic                      o_rs2_busy,
    output logic [(2**REG_AW)-1:0]    o_busy_vec
);

    localparam int unsigned PTR_W    = idx_w(NUM_SRC);
    localparam int unsigned NUM_REGS = 2 ** REG_AW;

    logic [NUM_SRC-1:0]  elig, zero_ack, grant;
    logic [PTR_W-1:0]    ptr, winner;
    logic                any_grant, issue_fire;
    logic [REG_AW-1:0]   win_rd;
    logic [XLEN-1:0]     win_data;
    logic [REG_AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Split requests into arbitrated writes and x0 writes that are simply acked
    always_comb begin
        elig     = '0;
        zero_ack = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (i_req_valid[k] && !i_flush) begin
                if (i_req_rd[k*REG_AW +: REG_AW] != '0) elig[k] = 1'b1;
                else                                     zero_ack[k] = 1'b1;
            end
        end
    end

    rf_wb_picker #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_elig   (elig),
        .i_ptr    (ptr),
        .o_grant  (grant),
        .o_winner (winner),
        .o_any    (any_grant)
    );

    assign o_req_ready = grant | zero_ack;

    // Mux the winner's rd/data; zero when nothing is granted
    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (grant[k]) begin
                win_rd   = i_req_rd[k*REG_AW +: REG_AW];
                win_data = i_req_data[k*XLEN +: XLEN];
            end
        end
    end

    assign waddr_d = win_rd;
    assign wdata_d = win_data;

`ifdef RF_WB_RR_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Pointer moves past the winner; flush returns it to source 0
    always_comb begin
        ptr_d = ptr_q;
        if (i_flush) begin
            ptr_d = '0;
        end else if (any_grant) begin
            ptr_d = (32'(winner) == NUM_SRC - 1) ? '0 : PTR_W'(32'(winner) + 1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (i_rst_n == RST_ACTIVE) ptr_q <= '0;
        else                       ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    logic unused_winner;
    assign unused_winner = ^winner;
    assign ptr = '0;
`endif

    // WAW stall: an issue may not target a register with a write still pending
    assign o_issue_ready = !i_flush && ((i_issue_rd == '0) || !busy_q[i_issue_rd]);
    assign issue_fire    = i_issue_valid && o_issue_ready && (i_issue_rd != '0);

    // Scoreboard next state: clear on the edge the write lands, set wins on collision
    always_comb begin
        busy_d = busy_q;
        if (i_flush) begin
            busy_d = '0;
        end else begin
            if (any_grant)  busy_d[win_rd]     = 1'b0;
            if (issue_fire) busy_d[i_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output write register and scoreboard state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (i_rst_n == RST_ACTIVE) begin
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign o_rd_waddr = waddr_q;
    assign o_rd_wdata = wdata_q;
    assign o_busy_vec = busy_q;
    assign o_rs1_busy = busy_q[i_rs1_addr];
    assign o_rs2_busy = busy_q[i_rs2_addr];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler (honours RF_WB_RR_EN).
module tb_rf_wb_scheduler;

    localparam int NS = 3;
    localparam int XL = 32;
    localparam int AW = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS-1:0]    req_valid;
    logic [NS*AW-1:0] req_rd;
    logic [NS*XL-1:0] req_data;
    logic [NS-1:0]    req_ready;
    logic [AW-1:0]    rd_waddr;
    logic [XL-1:0]    rd_wdata;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic             issue_ready;
    logic             flush;
    logic [AW-1:0]    rs1_addr, rs2_addr;
    logic             rs1_busy, rs2_busy;
    logic [31:0]      busy_vec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_wb_scheduler #(
        .NUM_SRC (NS),
        .XLEN    (XL),
        .REG_AW  (AW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_req_rd      (req_rd),
        .i_req_data    (req_data),
        .o_req_ready   (req_ready),
        .o_rd_waddr    (rd_waddr),
        .o_rd_wdata    (rd_wdata),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .o_issue_ready (issue_ready),
        .i_flush       (flush),
        .i_rs1_addr    (rs1_addr),
        .i_rs2_addr    (rs2_addr),
        .o_rs1_busy    (rs1_busy),
        .o_rs2_busy    (rs2_busy),
        .o_busy_vec    (busy_vec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [AW-1:0] rd,
                           input logic [XL-1:0] d);
        req_valid[k]         = v;
        req_rd[k*AW +: AW]   = rd;
        req_data[k*XL +: XL] = d;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        #12;
        rst_n = 1'b1;
        #1;
        chk("reset_waddr", 32'(rd_waddr), 32'd0);
        chk("reset_wdata", rd_wdata, 32'd0);
        chk("reset_busy", busy_vec, 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_issue_ready_x0", 32'(issue_ready), 32'd1);

        // ALU rd=3 and MDU rd=7 competing
        set_req(0, 1'b1, 5'd3, 32'hA3);
        set_req(2, 1'b1, 5'd7, 32'hA7);
        #1;
        chk("arb_c1_ready", 32'(req_ready), 32'b001);
        tick();
        chk("arb_c2_waddr", 32'(rd_waddr), 32'd3);
        chk("arb_c2_wdata", rd_wdata, 32'hA3);
`ifdef RF_WB_RR_EN
        // ALU keeps requesting; round-robin must hand the port to MDU next
        chk("rr_c2_ready", 32'(req_ready), 32'b100);
        tick();
        chk("rr_c3_waddr", 32'(rd_waddr), 32'd7);
        chk("rr_c3_wdata", rd_wdata, 32'hA7);
        chk("rr_c3_ready", 32'(req_ready), 32'b001);
        set_req(2, 1'b0, 5'd0, 32'd0);
        tick();
        chk("rr_c4_waddr", 32'(rd_waddr), 32'd3);
        set_req(0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("rr_idle_waddr", 32'(rd_waddr), 32'd0);
`else
        set_req(0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("fp_c2_ready", 32'(req_ready), 32'b100);
        tick();
        chk("fp_c3_waddr", 32'(rd_waddr), 32'd7);
        chk("fp_c3_wdata", rd_wdata, 32'hA7);
        set_req(2, 1'b0, 5'd0, 32'd0);
        #1;
        chk("fp_c3_ready", 32'(req_ready), 32'b000);
        tick();
        chk("fp_idle_waddr", 32'(rd_waddr), 32'd0);
        chk("fp_idle_wdata", rd_wdata, 32'd0);
`endif

        // Issue rd=5, then LSU writes it back
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        rs1_addr    = 5'd5;
        #1;
        chk("iss5_ready", 32'(issue_ready), 32'd1);
        chk("iss5_rs1_pre", 32'(rs1_busy), 32'd0);
        tick();
        issue_valid = 1'b0;
        chk("iss5_busy_vec", busy_vec, 32'h0000_0020);
        chk("iss5_rs1_busy", 32'(rs1_busy), 32'd1);
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("lsu_ready", 32'(req_ready), 32'b010);
        chk("lsu_rs1_busy_n", 32'(rs1_busy), 32'd1);
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        chk("lsu_waddr", 32'(rd_waddr), 32'd5);
        chk("lsu_wdata", rd_wdata, 32'hDEADBEEF);
        chk("lsu_busy_clr", busy_vec, 32'd0);
        chk("lsu_rs1_clr", 32'(rs1_busy), 32'd0);
        tick();
        chk("lsu_after_waddr", 32'(rd_waddr), 32'd0);

        // WAW stall on rd=9
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        #1;
        chk("waw_first_ready", 32'(issue_ready), 32'd1);
        tick();
        chk("waw_busy9", busy_vec, 32'h0000_0200);
        chk("waw_stall", 32'(issue_ready), 32'd0);
        set_req(2, 1'b1, 5'd9, 32'h99);
        #1;
        chk("waw_mdu_ready", 32'(req_ready), 32'b100);
        chk("waw_stall_hold", 32'(issue_ready), 32'd0);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);
        chk("waw_waddr", 32'(rd_waddr), 32'd9);
        chk("waw_wdata", rd_wdata, 32'h99);
        chk("waw_release", 32'(issue_ready), 32'd1);
        chk("waw_busy_clr", busy_vec, 32'd0);
        issue_valid = 1'b0;

        // x0 request acked alongside a real ALU write
        set_req(0, 1'b1, 5'd4, 32'h44);
        set_req(1, 1'b1, 5'd0, 32'h55);
        #1;
        chk("x0_ready", 32'(req_ready), 32'b011);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        set_req(1, 1'b0, 5'd0, 32'd0);
        chk("x0_waddr", 32'(rd_waddr), 32'd4);
        chk("x0_wdata", rd_wdata, 32'h44);
        tick();
        chk("x0_after_waddr", 32'(rd_waddr), 32'd0);

        // Build busy = {2, 6}
        issue_valid = 1'b1;
        issue_rd    = 5'd2;
        tick();
        issue_rd = 5'd6;
        tick();
        issue_valid = 1'b0;
        rs2_addr    = 5'd6;
        #1;
        chk("busy_2_6", busy_vec, 32'h0000_0044);
        chk("rs2_busy6", 32'(rs2_busy), 32'd1);

        // ALU writes rd=6, then flush while that write is in the output register
        set_req(0, 1'b1, 5'd6, 32'h66);
        #1;
        chk("pre_flush_ready", 32'(req_ready), 32'b001);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        flush       = 1'b1;
        set_req(1, 1'b1, 5'd2, 32'h22);
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        #1;
        chk("flush_ready", 32'(req_ready), 32'b000);
        chk("flush_issue_ready", 32'(issue_ready), 32'd0);
        chk("flush_waddr_completes", 32'(rd_waddr), 32'd6);
        chk("flush_busy_pre", busy_vec, 32'h0000_0004);
        tick();
        flush       = 1'b0;
        set_req(1, 1'b0, 5'd0, 32'd0);
        issue_valid = 1'b0;
        chk("flush_busy_clr", busy_vec, 32'd0);
        chk("flush_no_write", 32'(rd_waddr), 32'd0);

        // Async reset while a write is registered
        set_req(0, 1'b1, 5'd6, 32'h66);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        chk("rst_pre_waddr", 32'(rd_waddr), 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_waddr", 32'(rd_waddr), 32'd0);
        chk("rst_async_wdata", rd_wdata, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("rst_release_busy", busy_vec, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Schedules the single register-file write port among NUM_SRC writeback sources (ALU, LSU, MDU) using per-source valid/ready handshakes.
- Registers the winning write onto the register file's rd write-address/write-data inputs.
- Keeps a 32-entry pending-write scoreboard so decode can stall on RAW/WAW hazards.
- Sits between the execute-stage writeback sources and the register file, and feeds stall logic in decode.

Parameters:
- NUM_SRC, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = MDU).
- XLEN, 32, register data width.
- REG_AW, 5, register address width.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  NUM_SRC  per-source write request
- i_req_rd  in  NUM_SRC*REG_AW  per-source destination; slice k = [k*REG_AW +: REG_AW]
- i_req_data  in  NUM_SRC*XLEN  per-source write data; slice k = [k*XLEN +: XLEN]
- o_req_ready  out  NUM_SRC  per-source accept; request consumed on valid&ready
- o_rd_waddr  out  REG_AW  register-file write address; 0 = no write
- o_rd_wdata  out  XLEN  register-file write data
- i_issue_valid  in  1  decode issuing an instruction that will write i_issue_rd
- i_issue_rd  in  REG_AW  destination of the issuing instruction
- o_issue_ready  out  1  issue permitted (no WAW hazard)
- i_flush  in  1  pipeline flush
- i_rs1_addr  in  REG_AW  decode source 1 query
- i_rs2_addr  in  REG_AW  decode source 2 query
- o_rs1_busy  out  1  rs1 has a pending write
- o_rs2_busy  out  1  rs2 has a pending write
- o_busy_vec  out  32  scoreboard contents; bit 0 is always 0

Behaviour:
- Reset (async, active-low):
  - o_rd_waddr = 0, o_rd_wdata = 0.
  - busy_vec = 0, round-robin pointer = 0.
  - Combinational outputs follow from these values.
- Requests with rd == 0 get o_req_ready = 1 in the same cycle, never use the write port and never win arbitration. Suppressed while i_flush = 1.
- Eligible requests have valid = 1 and rd != 0. At most one is granted per cycle. The grant is o_req_ready[k] = 1 for the winner only, combinational from the current inputs and pointer.
- Latency is 1 cycle. A grant in cycle N loads the output register at the closing edge, so o_rd_waddr/o_rd_wdata carry the winner's rd/data for all of cycle N+1.
- With no grant, the output register loads waddr = 0 and wdata = 0. Outputs change only on posedge, so they are stable when the register file samples on negedge.
- Ungranted requesters must hold valid, rd and data stable until granted. The scheduler never drops a held request.
- Scoreboard:
  - Set: busy[i_issue_rd] is set on the edge where i_issue_valid & o_issue_ready & (i_issue_rd != 0).
  - Clear: busy[rd] is cleared on the edge that loads the output register with that rd, i.e. the same edge the write becomes visible.
  - Data availability: from cycle N+1 the register file's same-address bypass supplies the data and busy reads 0, so no bubble is needed.
- o_issue_ready = (i_issue_rd == 0) | ~busy[i_issue_rd]. This is a WAW stall; it prevents set and clear landing on the same register on the same edge. If set and clear nevertheless coincide, set wins.
- o_rsX_busy = busy[i_rsX_addr]; always 0 for address 0.
- i_flush:
  - Clears busy_vec at the edge.
  - Forces all o_req_ready = 0 and o_issue_ready = 0 during the flush cycle.
  - Resets the pointer to 0.
  - A write already in the output register still completes in the following cycle.
- Reset asserted mid-operation discards any registered write; o_rd_waddr returns to 0 immediately.
- Two sources requesting the same rd in one cycle: the winner writes first and the loser writes in a later cycle, so the last grant wins in the register file.

Optional Feature:
- Macro: RF_WB_RR_EN.
- Defined: round-robin arbitration. The search starts at the pointer; after each grant the pointer becomes (winner + 1) mod NUM_SRC. The pointer is unchanged when there is no grant.
- Undefined: fixed priority, lowest index wins (ALU > LSU > MDU). No pointer register is implemented.

Decomposition:
- Shared defines/package: REG_AW, XLEN, NUM_SRC default, source index constants SRC_ALU = 0, SRC_LSU = 1, SRC_MDU = 2, reset level constant.
- Sub-module rf_wb_picker: combinational one-hot winner select from eligible mask and pointer input. It contains the RR_EN variant switch.
- The scoreboard and output register stay in the top module.

Test Plan:
- Reset, then idle → o_rd_waddr = 0, o_rd_wdata = 0, o_busy_vec = 0, all ready = 0.
- Issue rd = 5, then LSU requests rd = 5, data = 0xDEADBEEF in cycle N → ready[1] = 1 in N; cycle N+1 shows waddr = 5, wdata = 0xDEADBEEF, busy[5] = 0; rs1 = 5 query shows busy = 1 before N+1.
- ALU (rd = 3) and MDU (rd = 7) both valid for 3 cycles:
  - fixed priority → grants ALU, MDU, then none;
  - with RF_WB_RR_EN and ALU re-requesting → grants alternate ALU, MDU.
- Issue rd = 9 while busy[9] = 1 → o_issue_ready = 0; after the rd = 9 write lands → o_issue_ready = 1.
- Request rd = 0 alongside ALU rd = 4 → both ready = 1 same cycle; only waddr = 4 appears next cycle.
- busy = {2, 6}, assert i_flush with LSU valid → ready = 0, busy_vec = 0 next cycle. Assert i_rst_n = 0 while waddr = 6 → waddr = 0 immediately.
